// File: rtl/beu_mc_ctrl_if.sv
// beu_mc_ctrl_if: EX issue, MA handoff and BEU unit bundle
// master = EX/MA/unit side, slave = controller side
interface beu_mc_ctrl_if #(
  parameter int F_W = 4
);
  logic           s_issue_i;
  logic [F_W-1:0] s_function_i;
  logic [31:0]    s_op1_i;
  logic [31:0]    s_op2_i;
  logic           s_flush_i;
  logic           s_ma_ready_i;
  logic           s_stall_o;
  logic           s_valid_o;
  logic [31:0]    s_result_o;
  logic           s_timeout_o;
  logic           s_unit_compute_o;
  logic           s_unit_flush_o;
  logic           s_unit_stall_o;
  logic [F_W-1:0] s_unit_function_o;
  logic [31:0]    s_unit_op1_o;
  logic [31:0]    s_unit_op2_o;
  logic           s_unit_finished_i;
  logic [31:0]    s_unit_result_i;

  modport master (
    output s_issue_i,
    output s_function_i,
    output s_op1_i,
    output s_op2_i,
    output s_flush_i,
    output s_ma_ready_i,
    output s_unit_finished_i,
    output s_unit_result_i,
    input  s_stall_o,
    input  s_valid_o,
    input  s_result_o,
    input  s_timeout_o,
    input  s_unit_compute_o,
    input  s_unit_flush_o,
    input  s_unit_stall_o,
    input  s_unit_function_o,
    input  s_unit_op1_o,
    input  s_unit_op2_o
  );

  modport slave (
    input  s_issue_i,
    input  s_function_i,
    input  s_op1_i,
    input  s_op2_i,
    input  s_flush_i,
    input  s_ma_ready_i,
    input  s_unit_finished_i,
    input  s_unit_result_i,
    output s_stall_o,
    output s_valid_o,
    output s_result_o,
    output s_timeout_o,
    output s_unit_compute_o,
    output s_unit_flush_o,
    output s_unit_stall_o,
    output s_unit_function_o,
    output s_unit_op1_o,
    output s_unit_op2_o
  );
endinterface

// File: rtl/beu_mc_ctrl.sv
// beu_mc_ctrl: issue sequencer for the iterative CLMUL path
// option: BEU_MC_ZERO_BYPASS_EN skips the unit on zero operands
module beu_mc_ctrl #(
  parameter int F_W     = 4,
  parameter int TIMEOUT = 40
) (
  input logic          s_clk_i,
  input logic          s_reset_i,
  beu_mc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state_q;
  logic [F_W-1:0] fn_q;
  logic [31:0]    op1_q;
  logic [31:0]    op2_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    res_q;
  logic           to_q;
  logic           byp_q;

  logic st_idle;
  logic st_busy;
  logic st_done;
  logic term;
  logic to_flush;
  logic zero_hit;

  assign st_idle  = (state_q == IDLE);
  assign st_busy  = (state_q == BUSY);
  assign st_done  = (state_q == DONE);
  assign term     = (cnt_q == CW'(TIMEOUT - 1));
  assign to_flush = st_busy & ~bus.s_unit_finished_i & term;

`ifdef BEU_MC_ZERO_BYPASS_EN
  assign zero_hit = (bus.s_op1_i == 32'd0) |
                    (bus.s_op2_i == 32'd0);
`else
  assign zero_hit = 1'b0;
`endif

  // sequencer state, latched op, counter and result registers
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      state_q <= IDLE;
      fn_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
      byp_q   <= 1'b0;
    end else if (bus.s_flush_i) begin
      state_q <= IDLE;
      to_q    <= 1'b0;
      byp_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (bus.s_issue_i) begin
            fn_q  <= bus.s_function_i;
            op1_q <= bus.s_op1_i;
            op2_q <= bus.s_op2_i;
            cnt_q <= '0;
            to_q  <= 1'b0;
            if (zero_hit) begin
              state_q <= DONE;
              res_q   <= '0;
              byp_q   <= 1'b1;
            end else begin
              state_q <= BUSY;
              byp_q   <= 1'b0;
            end
          end
        end
        st_busy: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus.s_unit_finished_i) begin
            res_q   <= bus.s_unit_result_i;
            to_q    <= 1'b0;
            state_q <= DONE;
          end else if (term) begin
            res_q   <= '0;
            to_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        st_done: begin
          if (bus.s_ma_ready_i) begin
            state_q <= IDLE;
            to_q    <= 1'b0;
            byp_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_stall_o = ~s_reset_i &
                         ((st_idle & bus.s_issue_i) |
                          st_busy |
                          (st_done & ~bus.s_ma_ready_i));

  assign bus.s_valid_o        = st_done;
  assign bus.s_result_o       = res_q;
  assign bus.s_timeout_o      = to_q;
  assign bus.s_unit_compute_o = st_busy |
                                (st_done & ~to_q & ~byp_q);
  assign bus.s_unit_flush_o   = s_reset_i |
                                bus.s_flush_i |
                                to_flush;
  assign bus.s_unit_stall_o   = st_done & ~bus.s_ma_ready_i;
  assign bus.s_unit_function_o = fn_q;
  assign bus.s_unit_op1_o     = op1_q;
  assign bus.s_unit_op2_o     = op2_q;

endmodule
